crc_generate: RTL

- Transmit-side counterpart of crc_validate.
- Latches a UDP payload word and computes its CRC-32 bit-serially, MSB-first.
- Streams the payload followed by the 32-bit CRC as a serial bit stream, and presents the CRC in parallel.
- Its output frame is exactly what crc_validate consumes: udp_rx equals the payload, sending_crc equals crc_out.

---
 rtl/crc_gen_if.sv | 24 ++
 rtl/crc_generate.sv | 126 ++++++++++++
 2 files changed

// File: rtl/crc_gen_if.sv
// Payload and serial-frame signals shared by the CRC-32 frame generator and its user.
// The master drives payload/start; the slave (generator) drives the frame and the parallel CRC.
interface crc_gen_if #(
    parameter int DATA_WIDTH = 176
);
    logic [DATA_WIDTH-1:0] udp_tx;
    logic                  udp_tx_start;
    logic                  busy;
    logic                  tx_bit;
    logic                  tx_bit_valid;
    logic                  tx_last;
    logic [31:0]           crc_out;
    logic                  crc_valid;

    modport master (
        output udp_tx, udp_tx_start,
        input  busy, tx_bit, tx_bit_valid, tx_last, crc_out, crc_valid
    );

    modport slave (
        input  udp_tx, udp_tx_start,
        output busy, tx_bit, tx_bit_valid, tx_last, crc_out, crc_valid
    );
endinterface

// File: rtl/crc_generate.sv
// Bit-serial CRC-32 frame generator: streams a latched payload MSB-first followed by its CRC,
// and presents the CRC in parallel once the payload has been consumed.
module crc_generate #(
    parameter int          DATA_WIDTH = 176,
    parameter logic [31:0] CRC_POLY   = 32'h04C11DB7,
    parameter logic [31:0] CRC_INIT   = 32'hFFFFFFFF,
    parameter logic [31:0] CRC_XOROUT = 32'hFFFFFFFF
) (
    input  logic     clk,
    input  logic     reset,
    crc_gen_if.slave bus
);
    // The counter must also index the 32 appended CRC bits, so it never shrinks below 5 bits.
    localparam int CNT_W = ($clog2(DATA_WIDTH) > 5) ? $clog2(DATA_WIDTH) : 5;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        APPEND
    } state_t;

    state_t                state_reg, state_next;
    logic [DATA_WIDTH-1:0] shreg_reg, shreg_next;
    logic [31:0]           lfsr_reg, lfsr_next;
    logic [CNT_W-1:0]      cnt_reg, cnt_next;
    logic [31:0]           crc_reg, crc_next;
    logic                  crc_valid_reg, crc_valid_next;

    logic        fb;
    logic [31:0] lfsr_step;

    assign fb = lfsr_reg[31] ^ shreg_reg[DATA_WIDTH-1];

    // One Galois LFSR step per payload bit; bit 0 has no lower neighbour to shift in.
    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_lfsr
            if (gi == 0) begin : g_lsb
                assign lfsr_step[gi] = fb & CRC_POLY[gi];
            end else begin : g_bit
                assign lfsr_step[gi] = lfsr_reg[gi-1] ^ (fb & CRC_POLY[gi]);
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            shreg_reg     <= '0;
            lfsr_reg      <= '0;
            cnt_reg       <= '0;
            crc_reg       <= '0;
            crc_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            shreg_reg     <= shreg_next;
            lfsr_reg      <= lfsr_next;
            cnt_reg       <= cnt_next;
            crc_reg       <= crc_next;
            crc_valid_reg <= crc_valid_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        shreg_next     = shreg_reg;
        lfsr_next      = lfsr_reg;
        cnt_next       = cnt_reg;
        crc_next       = crc_reg;
        crc_valid_next = crc_valid_reg;

        case (state_reg)
            IDLE: begin
                if (bus.udp_tx_start) begin
                    shreg_next     = bus.udp_tx;
                    lfsr_next      = CRC_INIT;
                    cnt_next       = CNT_W'(DATA_WIDTH - 1);
                    crc_valid_next = 1'b0;
                    state_next     = CALC;
                end
            end
            CALC: begin
                shreg_next = shreg_reg << 1;
                lfsr_next  = lfsr_step;
                if (cnt_reg == '0) begin
                    crc_next       = lfsr_step ^ CRC_XOROUT;
                    crc_valid_next = 1'b1;
                    cnt_next       = CNT_W'(31);
                    state_next     = APPEND;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            APPEND: begin
                if (cnt_reg == '0) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Serial outputs come straight from registered state, so the frame starts the cycle after start.
    always_comb begin
        bus.tx_bit       = 1'b0;
        bus.tx_bit_valid = 1'b0;
        bus.tx_last      = 1'b0;
        case (state_reg)
            CALC: begin
                bus.tx_bit       = shreg_reg[DATA_WIDTH-1];
                bus.tx_bit_valid = 1'b1;
            end
            APPEND: begin
                bus.tx_bit       = crc_reg[cnt_reg[4:0]];
                bus.tx_bit_valid = 1'b1;
                bus.tx_last      = (cnt_reg == '0);
            end
            default: ;
        endcase
    end

    assign bus.busy      = (state_reg != IDLE);
    assign bus.crc_out   = crc_reg;
    assign bus.crc_valid = crc_valid_reg;
endmodule
